// File: rtl/cpu_regfile_mp_if.sv
// Bus between decode/execute and the multi-port register file.
// The master side issues reads and writes. The slave side is the regfile.
interface cpu_regfile_mp_if #(
  parameter int p_data_w = 32,
  parameter int p_addr_w = 5,
  parameter int p_nb_rd  = 2
);
  logic                         o_busy;
  logic                         o_addr_oob;
  logic [p_nb_rd-1:0]           i_rd_req;
  logic [p_nb_rd*p_addr_w-1:0]  i_rd_addr;
  logic [p_nb_rd-1:0]           o_rd_valid;
  logic [p_nb_rd*p_data_w-1:0]  o_rd_data;
  logic                         o_rd_done;
  logic                         i_wr_en;
  logic [p_addr_w-1:0]          i_wr_addr;
  logic [p_data_w-1:0]          i_wr_data;

  modport master (
    input  o_busy, o_addr_oob, o_rd_valid, o_rd_data, o_rd_done,
    output i_rd_req, i_rd_addr, i_wr_en, i_wr_addr, i_wr_data
  );

  modport slave (
    output o_busy, o_addr_oob, o_rd_valid, o_rd_data, o_rd_done,
    input  i_rd_req, i_rd_addr, i_wr_en, i_wr_addr, i_wr_data
  );
endinterface

// File: rtl/cpu_regfile_mp.sv
// Multi-read-port register file on a single-port array.
// Read requests are serialised one port per cycle. Writes always win the port.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | zeroing x1..xD-1 after reset, one per cycle, bus ignored
// ST_IDLE  | writes accepted, a nonzero read mask is latched
// ST_READ  | lowest pending port read each cycle unless a write takes it
module cpu_regfile_mp #(
  parameter int p_data_w       = 32,
  parameter int p_addr_w       = 5,
  parameter int p_nb_rd        = 2,
  parameter int p_ext_rve      = 0,
  parameter int p_clear_on_rst = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  cpu_regfile_mp_if.slave   bus
);

  localparam int c_idx_w = (p_ext_rve != 0) ? p_addr_w - 1 : p_addr_w;
  localparam int c_depth = 1 << c_idx_w;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_READ} state_t;

  state_t                       state_q, state_d;
  logic [p_data_w-1:0]          mem [c_depth];
  logic [c_idx_w-1:0]           clr_cnt_q;
  logic [p_nb_rd-1:0]           pend_q, pend_d;
  logic [p_nb_rd*p_addr_w-1:0]  addr_q;
  logic [p_nb_rd-1:0]           valid_q;
  logic [p_nb_rd*p_data_w-1:0]  data_q;
  logic                         done_q;
  logic                         oob_q;

  logic                         accept;
  logic                         wr_cycle;
  logic                         rd_cycle;
  logic                         wr_ok;
  logic                         req_oob;
  logic [p_nb_rd-1:0]           rd_onehot;
  logic [p_addr_w-1:0]          rd_addr;
  logic [p_data_w-1:0]          rd_val;

  function automatic logic is_oob(input logic [p_addr_w-1:0] a);
    return {1'b0, a} >= (p_addr_w+1)'(c_depth);
  endfunction

  // Pick the lowest-index pending port and check the incoming mask for OOB.
  always_comb begin : pick
    rd_onehot = '0;
    rd_addr   = '0;
    req_oob   = 1'b0;
    for (int k = p_nb_rd - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        rd_onehot = p_nb_rd'(1) << k;
        rd_addr   = addr_q[k*p_addr_w +: p_addr_w];
      end
    end
    for (int k = 0; k < p_nb_rd; k++) begin
      req_oob = req_oob |
                (bus.i_rd_req[k] & is_oob(bus.i_rd_addr[k*p_addr_w +: p_addr_w]));
    end
  end

  assign wr_ok  = (bus.i_wr_addr != '0) && !is_oob(bus.i_wr_addr);
  assign rd_val = ((rd_addr == '0) || is_oob(rd_addr)) ? '0 : mem[rd_addr[c_idx_w-1:0]];

  // Next state and per-cycle port arbitration.
  always_comb begin : fsm_next
    state_d  = state_q;
    pend_d   = pend_q;
    accept   = 1'b0;
    wr_cycle = 1'b0;
    rd_cycle = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == c_idx_w'(1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        wr_cycle = bus.i_wr_en;
        if (bus.i_rd_req != '0) begin
          accept  = 1'b1;
          pend_d  = bus.i_rd_req;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        wr_cycle = bus.i_wr_en;
        if (!bus.i_wr_en) begin
          rd_cycle = 1'b1;
          pend_d   = pend_q & ~rd_onehot;
          if (pend_d == '0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; a reset always restarts the clear sequence when enabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin : fsm_reg
    if (!i_rst_n) state_q <= (p_clear_on_rst != 0) ? ST_CLEAR : ST_IDLE;
    else          state_q <= state_d;
  end

  // Clear down-counter: walks xD-1 down to x1, terminal count at 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin : clr_cnt
    if (!i_rst_n)                clr_cnt_q <= '1;
    else if (state_q == ST_CLEAR) clr_cnt_q <= clr_cnt_q - c_idx_w'(1);
  end

  // Single-port storage: one clear or write per cycle, never reset.
  always_ff @(posedge i_clk) begin : mem_wr
    if (state_q == ST_CLEAR)   mem[clr_cnt_q] <= '0;
    else if (wr_cycle && wr_ok) mem[bus.i_wr_addr[c_idx_w-1:0]] <= bus.i_wr_data;
  end

  // Read-side registers: latched request, held results and status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin : rd_regs
    if (!i_rst_n) begin
      pend_q  <= '0;
      addr_q  <= '0;
      valid_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      done_q <= rd_cycle && (pend_d == '0);
      oob_q  <= (wr_cycle && is_oob(bus.i_wr_addr)) || (accept && req_oob);
      if (accept) begin
        addr_q  <= bus.i_rd_addr;
        valid_q <= '0;
      end
      if (rd_cycle) begin
        for (int k = 0; k < p_nb_rd; k++) begin
          if (rd_onehot[k]) begin
            valid_q[k]                      <= 1'b1;
            data_q[k*p_data_w +: p_data_w] <= rd_val;
          end
        end
      end
    end
  end

  assign bus.o_busy     = (state_q != ST_IDLE);
  assign bus.o_addr_oob = oob_q;
  assign bus.o_rd_valid = valid_q;
  assign bus.o_rd_data  = data_q;
  assign bus.o_rd_done  = done_q;

endmodule

// File: tb/tb_cpu_regfile_mp.sv
// Directed bench for cpu_regfile_mp: three configurations share clock and reset.
// u0: 2 ports, full depth. u1: 4 ports. u2: RV32E half depth, 2 ports.
module tb_cpu_regfile_mp;
  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  int   cnt;

  cpu_regfile_mp_if #(.p_data_w(32), .p_addr_w(5), .p_nb_rd(2)) bus0 ();
  cpu_regfile_mp_if #(.p_data_w(32), .p_addr_w(5), .p_nb_rd(4)) bus1 ();
  cpu_regfile_mp_if #(.p_data_w(32), .p_addr_w(5), .p_nb_rd(2)) bus2 ();

  cpu_regfile_mp #(.p_data_w(32), .p_addr_w(5), .p_nb_rd(2), .p_ext_rve(0), .p_clear_on_rst(1))
    u0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
  cpu_regfile_mp #(.p_data_w(32), .p_addr_w(5), .p_nb_rd(4), .p_ext_rve(0), .p_clear_on_rst(1))
    u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
  cpu_regfile_mp #(.p_data_w(32), .p_addr_w(5), .p_nb_rd(2), .p_ext_rve(1), .p_clear_on_rst(1))
    u2 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.i_rd_req = '0; bus0.i_rd_addr = '0; bus0.i_wr_en = 0; bus0.i_wr_addr = '0; bus0.i_wr_data = '0;
    bus1.i_rd_req = '0; bus1.i_rd_addr = '0; bus1.i_wr_en = 0; bus1.i_wr_addr = '0; bus1.i_wr_data = '0;
    bus2.i_rd_req = '0; bus2.i_rd_addr = '0; bus2.i_wr_en = 0; bus2.i_wr_addr = '0; bus2.i_wr_data = '0;
    repeat (3) tick();

    // reset values
    chk("rst_busy",  bus0.o_busy, 1);
    chk("rst_valid", bus0.o_rd_valid, 0);
    chk("rst_data",  bus0.o_rd_data, 0);
    chk("rst_done",  bus0.o_rd_done, 0);
    chk("rst_oob",   bus0.o_addr_oob, 0);

    // clear sequence length for depth 32
    rst_n = 1'b1;
    cnt = 0;
    do begin tick(); cnt++; end while (bus0.o_busy && cnt < 100);
    chk("clear_cycles", cnt, 31);
    repeat (5) tick();
    chk("u2_idle", bus2.o_busy, 0);

    // T1: read x5, x31 after clear
    bus0.i_rd_req = 2'b11; bus0.i_rd_addr = {5'd31, 5'd5};
    tick();
    chk("t1_busy_acc", bus0.o_busy, 1);
    bus0.i_rd_req = 2'b00;
    tick();
    chk("t1_valid_e1", bus0.o_rd_valid, 2'b01);
    chk("t1_done_e1",  bus0.o_rd_done, 0);
    tick();
    chk("t1_valid_e2", bus0.o_rd_valid, 2'b11);
    chk("t1_done_e2",  bus0.o_rd_done, 1);
    chk("t1_busy_e2",  bus0.o_busy, 0);
    chk("t1_data",     bus0.o_rd_data, 64'h0);
    tick();
    chk("t1_done_off", bus0.o_rd_done, 0);

    // T2: write x3 then read x3, x0
    bus0.i_wr_en = 1; bus0.i_wr_addr = 5'd3; bus0.i_wr_data = 32'hDEADBEEF;
    tick();
    bus0.i_wr_en = 0;
    bus0.i_rd_req = 2'b11; bus0.i_rd_addr = {5'd0, 5'd3};
    tick();
    bus0.i_rd_req = 2'b00;
    tick();
    chk("t2_done_e1", bus0.o_rd_done, 0);
    tick();
    chk("t2_valid", bus0.o_rd_valid, 2'b11);
    chk("t2_done",  bus0.o_rd_done, 1);
    chk("t2_data",  bus0.o_rd_data, {32'h0, 32'hDEADBEEF});
    tick();
    chk("t2_done_off", bus0.o_rd_done, 0);

    // T3: 4 ports, mask 1010, write x9 on the first READ cycle
    bus1.i_wr_en = 1; bus1.i_wr_addr = 5'd7; bus1.i_wr_data = 32'h1234;
    tick();
    bus1.i_wr_en = 0;
    bus1.i_rd_req = 4'b1010; bus1.i_rd_addr = {5'd9, 5'd0, 5'd7, 5'd0};
    tick();
    bus1.i_rd_req = 4'b0000;
    bus1.i_wr_en = 1; bus1.i_wr_addr = 5'd9; bus1.i_wr_data = 32'h55;
    tick();
    bus1.i_wr_en = 0;
    chk("t3_valid_e1", bus1.o_rd_valid, 4'b0000);
    tick();
    chk("t3_valid_e2", bus1.o_rd_valid, 4'b0010);
    chk("t3_done_e2",  bus1.o_rd_done, 0);
    tick();
    chk("t3_valid_e3", bus1.o_rd_valid, 4'b1010);
    chk("t3_done_e3",  bus1.o_rd_done, 1);
    chk("t3_busy_e3",  bus1.o_busy, 0);
    chk("t3_port3",    bus1.o_rd_data[127:96], 32'h55);
    chk("t3_port1",    bus1.o_rd_data[63:32], 32'h1234);

    // T4: RV32E, OOB write x20 and OOB read x17
    bus2.i_wr_en = 1; bus2.i_wr_addr = 5'd4; bus2.i_wr_data = 32'h44;
    tick();
    chk("t4_oob_inb", bus2.o_addr_oob, 0);
    bus2.i_wr_addr = 5'd20; bus2.i_wr_data = 32'hAA;
    tick();
    bus2.i_wr_en = 0;
    chk("t4_oob_wr", bus2.o_addr_oob, 1);
    tick();
    chk("t4_oob_wr_off", bus2.o_addr_oob, 0);
    bus2.i_rd_req = 2'b11; bus2.i_rd_addr = {5'd4, 5'd17};
    tick();
    bus2.i_rd_req = 2'b00;
    chk("t4_oob_rd", bus2.o_addr_oob, 1);
    tick();
    chk("t4_oob_rd_off", bus2.o_addr_oob, 0);
    chk("t4_valid_e1",   bus2.o_rd_valid, 2'b01);
    tick();
    chk("t4_valid", bus2.o_rd_valid, 2'b11);
    chk("t4_done",  bus2.o_rd_done, 1);
    chk("t4_data",  bus2.o_rd_data, {32'h44, 32'h0});

    // T5: reset mid-READ of a 3-port request
    bus1.i_rd_req = 4'b0111; bus1.i_rd_addr = {5'd0, 5'd7, 5'd9, 5'd7};
    tick();
    bus1.i_rd_req = 4'b0000;
    tick();
    chk("t5_valid_pre", bus1.o_rd_valid, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("t5_valid_rst", bus1.o_rd_valid, 0);
    chk("t5_data_rst",  bus1.o_rd_data, 0);
    chk("t5_done_rst",  bus1.o_rd_done, 0);
    chk("t5_busy_rst",  bus1.o_busy, 1);
    repeat (3) tick();
    chk("t5_done_hold", bus1.o_rd_done, 0);
    rst_n = 1'b1;
    cnt = 0;
    do begin
      tick(); cnt++;
      if (bus1.o_rd_done) chk("t5_no_done", bus1.o_rd_done, 0);
    end while (bus1.o_busy && cnt < 100);
    chk("t5_clear_cycles", cnt, 31);
    bus1.i_rd_req = 4'b0001; bus1.i_rd_addr = {5'd0, 5'd0, 5'd0, 5'd7};
    tick();
    bus1.i_rd_req = 4'b0000;
    tick();
    chk("t5_x7_cleared", bus1.o_rd_data[31:0], 32'h0);
    chk("t5_x7_done",    bus1.o_rd_done, 1);

    // T6: request held across busy is accepted exactly once more
    repeat (2) tick();
    bus0.i_wr_en = 1; bus0.i_wr_addr = 5'd3; bus0.i_wr_data = 32'h77;
    tick();
    bus0.i_wr_en = 0;
    bus0.i_rd_req = 2'b11; bus0.i_rd_addr = {5'd3, 5'd3};
    tick();
    tick();
    chk("t6_valid_e1", bus0.o_rd_valid, 2'b01);
    chk("t6_busy_e1",  bus0.o_busy, 1);
    tick();
    chk("t6_done_e2",  bus0.o_rd_done, 1);
    chk("t6_busy_e2",  bus0.o_busy, 0);
    tick();
    chk("t6_reacc_busy",  bus0.o_busy, 1);
    chk("t6_reacc_valid", bus0.o_rd_valid, 2'b00);
    bus0.i_rd_req = 2'b00;
    tick();
    chk("t6_valid_e4", bus0.o_rd_valid, 2'b01);
    tick();
    chk("t6_done_e5", bus0.o_rd_done, 1);
    chk("t6_data",    bus0.o_rd_data, {32'h77, 32'h77});
    tick();
    chk("t6_idle",     bus0.o_busy, 0);
    chk("t6_done_off", bus0.o_rd_done, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
